// File: rtl/serial_adder_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl_if
// Purpose : Handshake and operand/result bundle for the bit-serial adder
//           sequencer.
// Signals : start, a, b, cin  -- request and operands (master -> slave)
//           busy, done        -- progress handshake   (slave -> master)
//           sum, cout         -- registered result    (slave -> master)
// Modports: master (requester side), slave (sequencer side)
// -----------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
// Purpose : Bit-serial adder sequencer. One full-adder cell (two half adders
//           plus an OR) is walked across the operands LSB first, one bit per
//           clock. start is accepted in IDLE; busy is high for WIDTH cycles,
//           then done pulses for one cycle with sum/cout updated.
// Ports   : clk    -- system clock, rising edge
//           rst_n  -- asynchronous active-low reset
//           bus    -- serial_adder_ctrl_if.slave
//                     start/a/b/cin in, busy/done/sum/cout out
// Params  : WIDTH  -- operand/result width (2..32)
//           CW     -- bit-counter width, 2**CW > WIDTH
// -----------------------------------------------------------------------------

// Half adder used twice to build the shared full-adder cell.
module sa_half_adder (
  input  logic i_x,
  input  logic i_y,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_x ^ i_y;
  assign o_c = i_x & i_y;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_adder_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_load;
  logic             w_step;
  logic             w_last;

  logic             w_ha0_s;
  logic             w_ha0_c;
  logic             w_bit_s;
  logic             w_ha1_c;
  logic             w_carry_nxt;
  logic [WIDTH-1:0] w_s_sh_nxt;

  // Shared full-adder cell: HA(a,b) then HA(partial, carry), carries ORed.
  sa_half_adder u_ha0 (
    .i_x (r_a_sh[0]),
    .i_y (r_b_sh[0]),
    .o_s (w_ha0_s),
    .o_c (w_ha0_c)
  );

  sa_half_adder u_ha1 (
    .i_x (w_ha0_s),
    .i_y (r_carry),
    .o_s (w_bit_s),
    .o_c (w_ha1_c)
  );

  assign w_carry_nxt = w_ha0_c | w_ha1_c;
  assign w_s_sh_nxt  = {w_bit_s, r_s_sh[WIDTH-1:1]};

  assign w_load = (r_state == S_IDLE) && bus.start;
  assign w_step = (r_state == S_RUN);
  assign w_last = w_step && (r_cnt == CW'(WIDTH - 1));

  // --- state register ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --- next-state logic; any unexpected encoding falls back to IDLE ---
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_state_nxt = bus.start ? S_RUN : S_IDLE;
      S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --- serial datapath: capture in IDLE, one bit per edge in RUN ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_a_sh  <= bus.a;
      r_b_sh  <= bus.b;
      r_carry <= bus.cin;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_s_sh  <= w_s_sh_nxt;
      r_carry <= w_carry_nxt;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // --- result register: updated only on the edge that enters DONE ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_last) begin
      // The final bit is not yet in r_s_sh, so take the shifted-in view.
      r_sum  <= w_s_sh_nxt;
      r_cout <= w_carry_nxt;
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.done = (r_state == S_DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder sequencer built around one shared 1-bit adder cell: two half-adder instances plus an OR form a full adder.
- Adds two WIDTH-bit operands plus carry-in by walking the cell across the operands LSB first, one bit per clock.
- Controlled by a start/busy/done handshake.
- Serves as the sequential counterpart to the team's combinational adder cells for board labs: SW supplies operands, LEDs display the result.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2 to 32.
- CW, 6, bit-counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while an addition is in progress (RUN state).
- done  output  1  one-cycle pulse; the result is valid from this cycle on.
- sum  output  WIDTH  registered result; holds its value until the next completion.
- cout  output  1  registered carry-out of the MSB; holds with sum.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (rst_n low, at any time including mid-RUN):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry flop and bit counter cleared.
  - Takes effect immediately, without waiting for a clock edge. The in-flight operation is discarded and no done is issued.
- States: IDLE, RUN, DONE. Encoding is free; no unreachable-state lockup allowed (default transition to IDLE).
- IDLE:
  - On an edge with start=1: load a_sh=a, b_sh=b, carry=cin, cnt=0; go to RUN.
  - With start=0: remain in IDLE.
- RUN, at each edge:
  - s = a_sh[0]^b_sh[0]^carry, computed by the shared HA/HA/OR cell.
  - carry <= (a_sh[0]&b_sh[0]) | (carry&(a_sh[0]^b_sh[0])).
  - s_sh <= {s, s_sh[WIDTH-1:1]}.
  - a_sh and b_sh shift right by 1; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: also load sum <= {s, s_sh[WIDTH-1:1]} and cout <= the new carry; go to DONE.
- DONE: done=1 for exactly this cycle; next edge goes to IDLE unconditionally.
- Outputs: busy = (state==RUN); done = (state==DONE); both decoded from registered state, no combinational path from inputs.
- Latency: start accepted at edge k; busy high in cycles k..k+WIDTH-1 (after edges k..k+WIDTH-1); done and new sum/cout appear after edge k+WIDTH.
  - Minimum repeat period with start held high is WIDTH+2 cycles.
- Ignored inputs:
  - start in RUN or DONE is ignored, not queued.
  - a, b and cin changes after capture do not affect the in-flight result.
- sum/cout change only on the DONE-entry edge or on reset.
- Wrap-around: the result is modulo 2^WIDTH, and the overflow bit appears on cout only.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulse at edge 0 -> busy for 8 cycles, done pulse after edge 8, sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; repeat with a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start 0x12+0x34, then toggle a/b/cin and pulse start during RUN -> exactly one done, sum=0x46, no second operation begins.
- Start held high continuously with a=0x01, b=0x01 -> done pulses every 10 cycles, sum=0x02 each time, busy low in each DONE cycle.
- Assert rst_n=0 asynchronously mid-RUN (after 4 bits) -> busy, done, sum and cout go to 0 immediately. After release, a new 0x0F+0x01 yields sum=0x10, cout=0 with no stale done.
- Randomized 1000 operations against a reference model (a+b+cin) -> sum/cout match; done always exactly WIDTH cycles after the accepting edge.
